// File: rtl/data_table_mrd.sv
// -----------------------------------------------------------------------------
// data_table_mrd
//   Shared data table: a 2**A_WIDTH x D_WIDTH simple-dual-port RAM whose single
//   read port is shared by RD_CH_CNT read channels through a round-robin
//   arbiter. The write port is independent and never stalled. A read granted in
//   cycle t returns RAM_LATENCY cycles later, tagged with its channel, and sees
//   every write up to and including cycle t (write-first bypass).
//
// Ports
//   clk_i       in   1                  clock
//   rst_n_i     in   1                  asynchronous active-low reset
//   rd_req_i    in   RD_CH_CNT          per-channel read request (held until granted)
//   rd_addr_i   in   RD_CH_CNT*A_WIDTH  channel c address at [c*A_WIDTH +: A_WIDTH]
//   rd_ready_o  out  RD_CH_CNT          one-hot grant, request accepted this cycle
//   rd_valid_o  out  1                  read result valid (single cycle pulse)
//   rd_ch_o     out  CH_W               channel that issued the returned read
//   rd_data_o   out  D_WIDTH            read result
//   wr_en_i     in   1                  write strobe
//   wr_addr_i   in   A_WIDTH            write address
//   wr_data_i   in   D_WIDTH            write data
// -----------------------------------------------------------------------------
module data_table_mrd #(
  parameter int A_WIDTH     = 10,
  parameter int D_WIDTH     = 64,
  parameter int RD_CH_CNT   = 4,
  parameter int RAM_LATENCY = 2,
  localparam int CH_W       = $clog2(RD_CH_CNT)
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [RD_CH_CNT-1:0]           rd_req_i,
  input  logic [RD_CH_CNT*A_WIDTH-1:0]   rd_addr_i,
  output logic [RD_CH_CNT-1:0]           rd_ready_o,
  output logic                           rd_valid_o,
  output logic [CH_W-1:0]                rd_ch_o,
  output logic [D_WIDTH-1:0]             rd_data_o,
  input  logic                           wr_en_i,
  input  logic [A_WIDTH-1:0]             wr_addr_i,
  input  logic [D_WIDTH-1:0]             wr_data_i
);

  localparam int DEPTH = 1 << A_WIDTH;

  logic [D_WIDTH-1:0]   mem_q [DEPTH];
  logic [A_WIDTH-1:0]   ch_addr_s [RD_CH_CNT];

  logic [CH_W-1:0]      last_q;
  logic [CH_W-1:0]      last_d;
  logic [RD_CH_CNT-1:0] grant_s;
  logic                 grant_vld_s;
  logic [CH_W-1:0]      grant_ch_s;
  logic [A_WIDTH-1:0]   rd_addr_s;
  logic [D_WIDTH-1:0]   rd_word_s;

  // Source of the final output stage (either the issue itself or the last
  // internal pipeline stage, depending on RAM_LATENCY).
  logic                 src_vld_s;
  logic [CH_W-1:0]      src_ch_s;
  logic [D_WIDTH-1:0]   src_data_s;

  logic                 rd_valid_q;
  logic [CH_W-1:0]      rd_ch_q;
  logic [D_WIDTH-1:0]   rd_data_q;

  // Unpack the flat per-channel address bus.
  for (genvar c = 0; c < RD_CH_CNT; c++) begin : g_addr
    assign ch_addr_s[c] = rd_addr_i[c*A_WIDTH +: A_WIDTH];
  end

  // Round-robin grant: search last+1, last+2, ... (mod RD_CH_CNT); nothing is
  // granted while reset is asserted.
  always_comb begin
    int              idx;
    logic [CH_W-1:0] cand;
    grant_s     = '0;
    grant_vld_s = 1'b0;
    grant_ch_s  = '0;
    idx         = 0;
    cand        = '0;
    for (int i = 1; i <= RD_CH_CNT; i++) begin
      idx  = int'(last_q) + i;
      idx  = (idx >= RD_CH_CNT) ? (idx - RD_CH_CNT) : idx;
      cand = CH_W'(idx);
      if (rst_n_i && !grant_vld_s && rd_req_i[cand]) begin
        grant_vld_s   = 1'b1;
        grant_ch_s    = cand;
        grant_s[cand] = 1'b1;
      end else begin
        grant_vld_s   = grant_vld_s;
      end
    end
  end

  // Pointer next state, granted address and write-first read word.
  always_comb begin
    last_d    = grant_vld_s ? grant_ch_s : last_q;
    rd_addr_s = ch_addr_s[grant_ch_s];
    // A write to the same address in the issue cycle wins over the stored word.
    rd_word_s = (wr_en_i && (wr_addr_i == rd_addr_s)) ? wr_data_i : mem_q[rd_addr_s];
  end

  assign rd_ready_o = grant_s;

  // Arbiter pointer; after reset channel 0 is first in line.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= CH_W'(RD_CH_CNT - 1);
    end else begin
      last_q <= last_d;
    end
  end

  // Table storage; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  if (RAM_LATENCY == 1) begin : g_lat1
    assign src_vld_s  = grant_vld_s;
    assign src_ch_s   = grant_ch_s;
    assign src_data_s = rd_word_s;
  end else begin : g_latn
    localparam int STG = RAM_LATENCY - 1;

    logic [STG-1:0]     vld_q;
    logic [CH_W-1:0]    ch_q   [STG];
    logic [D_WIDTH-1:0] data_q [STG];

    // Valid bits of the internal stages; reset discards in-flight reads.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= grant_vld_s;
        for (int s = 1; s < STG; s++) begin
          vld_q[s] <= vld_q[s-1];
        end
      end
    end

    // Payload of the internal stages; only meaningful alongside its valid bit.
    always_ff @(posedge clk_i) begin
      ch_q[0]   <= grant_ch_s;
      data_q[0] <= rd_word_s;
      for (int s = 1; s < STG; s++) begin
        ch_q[s]   <= ch_q[s-1];
        data_q[s] <= data_q[s-1];
      end
    end

    assign src_vld_s  = vld_q[STG-1];
    assign src_ch_s   = ch_q[STG-1];
    assign src_data_s = data_q[STG-1];
  end

  // Output stage; channel and data hold their last values between returns.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_valid_q <= 1'b0;
      rd_ch_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= src_vld_s;
      if (src_vld_s) begin
        rd_ch_q   <= src_ch_s;
        rd_data_q <= src_data_s;
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_ch_o    = rd_ch_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_data_table_mrd.sv
module tb_data_table_mrd;

  typedef struct packed {
    logic [1:0]  ch;
    logic [63:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cyc = 32'd0;
  int          n_pass = 0;
  int          n_total = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // main DUT: A_WIDTH=10, RAM_LATENCY=2
  logic [3:0]  req_a;
  logic [39:0] raddr_a;
  logic        wen_a;
  logic [9:0]  waddr_a;
  logic [63:0] wdata_a;
  logic [3:0]  rdy_a;
  logic        vld_a;
  logic [1:0]  ch_a;
  logic [63:0] data_a;

  // small DUTs: A_WIDTH=4, RAM_LATENCY=1 and 4, shared inputs
  logic [3:0]  req_b;
  logic [15:0] raddr_b;
  logic        wen_b;
  logic [3:0]  waddr_b;
  logic [63:0] wdata_b;
  logic [3:0]  rdy_b1;
  logic        vld_b1;
  logic [1:0]  ch_b1;
  logic [63:0] data_b1;
  logic [3:0]  rdy_b4;
  logic        vld_b4;
  logic [1:0]  ch_b4;
  logic [63:0] data_b4;

  localparam logic [63:0] D5   = 64'h0000_0000_0000_00A5;
  localparam logic [63:0] D7A  = 64'h0000_0000_0000_0011;
  localparam logic [63:0] D7B  = 64'h0000_0000_0000_0077;
  localparam logic [63:0] D7C  = 64'h0000_0000_0000_0099;
  localparam logic [63:0] DTOP = 64'hFFFF_0000_0000_03FF;
  localparam logic [63:0] E15  = 64'hF00D_0000_0000_000F;
  localparam logic [39:0] ADDR_T4 = {10'd19, 10'd18, 10'd17, 10'd16};
  localparam logic [15:0] ADDR_B4 = {4'd3, 4'd2, 4'd1, 4'd0};

  logic [63:0] dt_main [4] = '{64'hC0DE_0000_0000_0016, 64'hC0DE_0000_0000_0017,
                               64'hC0DE_0000_0000_0018, 64'hC0DE_0000_0000_0019};
  logic [63:0] dt_small [4] = '{64'h0000_0000_0000_00B0, 64'h0000_0000_0000_00B1,
                                64'h0000_0000_0000_00B2, 64'h0000_0000_0000_00B3};

  data_table_mrd #(.A_WIDTH(10), .D_WIDTH(64), .RD_CH_CNT(4), .RAM_LATENCY(2)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .rd_req_i(req_a), .rd_addr_i(raddr_a),
    .rd_ready_o(rdy_a), .rd_valid_o(vld_a), .rd_ch_o(ch_a), .rd_data_o(data_a),
    .wr_en_i(wen_a), .wr_addr_i(waddr_a), .wr_data_i(wdata_a));

  data_table_mrd #(.A_WIDTH(4), .D_WIDTH(64), .RD_CH_CNT(4), .RAM_LATENCY(1)) u_dut_b1 (
    .clk_i(clk), .rst_n_i(rst_n), .rd_req_i(req_b), .rd_addr_i(raddr_b),
    .rd_ready_o(rdy_b1), .rd_valid_o(vld_b1), .rd_ch_o(ch_b1), .rd_data_o(data_b1),
    .wr_en_i(wen_b), .wr_addr_i(waddr_b), .wr_data_i(wdata_b));

  data_table_mrd #(.A_WIDTH(4), .D_WIDTH(64), .RD_CH_CNT(4), .RAM_LATENCY(4)) u_dut_b4 (
    .clk_i(clk), .rst_n_i(rst_n), .rd_req_i(req_b), .rd_addr_i(raddr_b),
    .rd_ready_o(rdy_b4), .rd_valid_o(vld_b4), .rd_ch_o(ch_b4), .rd_data_o(data_b4),
    .wr_en_i(wen_b), .wr_addr_i(waddr_b), .wr_data_i(wdata_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic mon_one(input int id, input logic v, input logic [1:0] ch, input logic [63:0] d);
    exp_t e;
    int   sz;
    if (v === 1'b1) begin
      sz = (id == 0) ? q0.size() : ((id == 1) ? q1.size() : q2.size());
      if (sz == 0) begin
        chk($sformatf("dut%0d_unexpected_valid", id), {63'd0, v}, 64'd0);
      end else begin
        case (id)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        chk($sformatf("dut%0d_ch", id), {62'd0, ch}, {62'd0, e.ch});
        chk($sformatf("dut%0d_data", id), d, e.data);
        chk($sformatf("dut%0d_latency", id), {32'd0, cyc}, {32'd0, e.cyc});
      end
    end
  endtask

  // Monitor: compares every returned read against the scoreboard queues.
  always @(negedge clk) begin
    mon_one(0, vld_a, ch_a, data_a);
    mon_one(1, vld_b1, ch_b1, data_b1);
    mon_one(2, vld_b4, ch_b4, data_b4);
  end

  task automatic drive_a(input logic [3:0] req, input logic [39:0] ra, input logic we,
                         input logic [9:0] wa, input logic [63:0] wd, input logic [3:0] erdy,
                         input logic [1:0] ech, input logic [63:0] ed, input string nm);
    @(negedge clk);
    req_a = req; raddr_a = ra; wen_a = we; waddr_a = wa; wdata_a = wd;
    #1;
    chk({nm, "_rdy"}, {60'd0, rdy_a}, {60'd0, erdy});
    if (erdy != 4'b0000) q0.push_back('{ch: ech, data: ed, cyc: cyc + 32'd2});
  endtask

  task automatic drive_b(input logic [3:0] req, input logic [15:0] ra, input logic we,
                         input logic [3:0] wa, input logic [63:0] wd, input logic [3:0] erdy,
                         input logic [1:0] ech, input logic [63:0] ed, input string nm);
    @(negedge clk);
    req_b = req; raddr_b = ra; wen_b = we; waddr_b = wa; wdata_b = wd;
    #1;
    chk({nm, "_rdy_l1"}, {60'd0, rdy_b1}, {60'd0, erdy});
    chk({nm, "_rdy_l4"}, {60'd0, rdy_b4}, {60'd0, erdy});
    if (erdy != 4'b0000) begin
      q1.push_back('{ch: ech, data: ed, cyc: cyc + 32'd1});
      q2.push_back('{ch: ech, data: ed, cyc: cyc + 32'd4});
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    req_a = 4'b1111; raddr_a = 40'd0; wen_a = 1'b0; waddr_a = 10'd0; wdata_a = 64'd0;
    req_b = 4'b1111; raddr_b = 16'd0; wen_b = 1'b0; waddr_b = 4'd0;  wdata_b = 64'd0;

    // reset state: no grants even with all requests high, outputs cleared
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdy_a", {60'd0, rdy_a}, 64'd0);
    chk("rst_rdy_l1", {60'd0, rdy_b1}, 64'd0);
    chk("rst_rdy_l4", {60'd0, rdy_b4}, 64'd0);
    chk("rst_valid", {63'd0, vld_a}, 64'd0);
    chk("rst_ch", {62'd0, ch_a}, 64'd0);
    chk("rst_data", data_a, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; req_a = 4'b0000; req_b = 4'b0000;

    // preload main table
    for (int i = 0; i < 4; i++)
      drive_a(4'b0000, 40'd0, 1'b1, 10'(16 + i), dt_main[i], 4'b0000, 2'd0, 64'd0, "wr");
    drive_a(4'b0000, 40'd0, 1'b1, 10'd7, D7A, 4'b0000, 2'd0, 64'd0, "wr");
    drive_a(4'b0000, 40'd0, 1'b1, 10'd1023, DTOP, 4'b0000, 2'd0, 64'd0, "wr");

    // T2: write addr 5, idle, ch2 reads it
    drive_a(4'b0000, 40'd0, 1'b1, 10'd5, D5, 4'b0000, 2'd0, 64'd0, "t2_wr");
    drive_a(4'b0000, 40'd0, 1'b0, 10'd0, 64'd0, 4'b0000, 2'd0, 64'd0, "t2_idle");
    drive_a(4'b0100, {4{10'd5}}, 1'b0, 10'd0, 64'd0, 4'b0100, 2'd2, D5, "t2_rd");

    // T3: same-cycle bypass, later write must not leak into the earlier read
    drive_a(4'b0010, {4{10'd7}}, 1'b0, 10'd0, 64'd0, 4'b0010, 2'd1, D7A, "t3_pre");
    drive_a(4'b0010, {4{10'd7}}, 1'b1, 10'd7, D7B, 4'b0010, 2'd1, D7B, "t3_byp");
    drive_a(4'b0000, 40'd0, 1'b1, 10'd7, D7C, 4'b0000, 2'd0, 64'd0, "t3_late");
    drive_a(4'b0001, {4{10'd7}}, 1'b0, 10'd0, 64'd0, 4'b0001, 2'd0, D7C, "t3_post");
    drive_a(4'b1000, {4{10'd1023}}, 1'b0, 10'd0, 64'd0, 4'b1000, 2'd3, DTOP, "top_addr");

    // T1: three reads issued, reset pulsed between edges mid-pipeline
    drive_a(4'b0001, ADDR_T4, 1'b0, 10'd0, 64'd0, 4'b0001, 2'd0, dt_main[0], "t1_r0");
    drive_a(4'b0010, ADDR_T4, 1'b0, 10'd0, 64'd0, 4'b0010, 2'd1, dt_main[1], "t1_r1");
    drive_a(4'b0100, ADDR_T4, 1'b0, 10'd0, 64'd0, 4'b0100, 2'd2, dt_main[2], "t1_r2");
    @(posedge clk);
    #2;
    req_a = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk("t1_valid", {63'd0, vld_a}, 64'd0);
    chk("t1_ch", {62'd0, ch_a}, 64'd0);
    chk("t1_data", data_a, 64'd0);
    q0.delete(); q1.delete(); q2.delete();
    #1;
    rst_n = 1'b1;

    // T4: all channels request; first grant ch0 after reset
    for (int i = 0; i < 8; i++) begin
      c = i % 4;
      drive_a(4'b1111, ADDR_T4, 1'b0, 10'd0, 64'd0, 4'b0001 << c, 2'(c), dt_main[c], "t4");
    end

    // T5: set last=1, then ch1/ch3 only -> 3,1,3,1
    drive_a(4'b0010, ADDR_T4, 1'b0, 10'd0, 64'd0, 4'b0010, 2'd1, dt_main[1], "t5_set");
    for (int i = 0; i < 4; i++) begin
      c = (i % 2 == 0) ? 3 : 1;
      drive_a(4'b1010, ADDR_T4, 1'b0, 10'd0, 64'd0, 4'b0001 << c, 2'(c), dt_main[c], "t5");
    end
    for (int i = 0; i < 4; i++)
      drive_a(4'b0000, 40'd0, 1'b0, 10'd0, 64'd0, 4'b0000, 2'd0, 64'd0, "idle_a");

    // T6: latency 1 and 4, A_WIDTH=4
    for (int i = 0; i < 4; i++)
      drive_b(4'b0000, 16'd0, 1'b1, 4'(i), dt_small[i], 4'b0000, 2'd0, 64'd0, "t6_wr");
    drive_b(4'b0000, 16'd0, 1'b1, 4'd5, D5, 4'b0000, 2'd0, 64'd0, "t6_wr5");
    drive_b(4'b0000, 16'd0, 1'b0, 4'd0, 64'd0, 4'b0000, 2'd0, 64'd0, "t6_idle");
    drive_b(4'b0100, {4{4'd5}}, 1'b0, 4'd0, 64'd0, 4'b0100, 2'd2, D5, "t6_t2");
    drive_b(4'b1000, {4{4'd15}}, 1'b1, 4'd15, E15, 4'b1000, 2'd3, E15, "t6_top_byp");
    drive_b(4'b0001, {4{4'd15}}, 1'b0, 4'd0, 64'd0, 4'b0001, 2'd0, E15, "t6_top");
    for (int i = 0; i < 8; i++) begin
      c = (i + 1) % 4;
      drive_b(4'b1111, ADDR_B4, 1'b0, 4'd0, 64'd0, 4'b0001 << c, 2'(c), dt_small[c], "t6_t4");
    end
    for (int i = 0; i < 6; i++)
      drive_b(4'b0000, 16'd0, 1'b0, 4'd0, 64'd0, 4'b0000, 2'd0, 64'd0, "idle_b");

    // every expected return must have arrived within the drain window
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
    chk("drain_q2", 64'(q2.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
